bool3_resp_checker: RTL and testbench

Hardware response checker for 3-input combinational lab blocks: the receiving end of the a/b/c stimulus stream that drives a device under test. Each cycle it samples a qualified input vector together with the DUT's output, compares the output against a parameterized 8-entry truth table, and accumulates a mismatch count, vector coverage and the first failing vector. It sits beside the DUT in simulation benches and on-board self-test wrappers, and produces a single pass/fail verdict.

---
 rtl/bool3_resp_checker.sv | 160 ++++++++++++++++
 tb/tb_bool3_resp_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bool3_resp_checker.sv
// bool3_resp_checker: response checker for 3-input combinational lab blocks.
// Compares each qualified DUT output e against truth table TT[{a,b,c}],
// accumulating saturating error/sample counts, vector coverage and the
// first failing vector, and reports a pass/fail verdict.
//
// Optional build macro: BOOL_CHK_HALT_EN
//   defined   -> first mismatch moves to FAIL and freezes all results
//                until rst_n=0 or clr=1.
//   undefined -> FAIL never entered; checking continues through mismatches.
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | after reset/clr, no sample accepted yet
// RUN   | at least one sample accepted, coverage incomplete
// DONE  | all 8 vectors seen; samples still checked and counted
// FAIL  | halted on first mismatch (BOOL_CHK_HALT_EN only)

module bool3_resp_checker #(
  parameter logic [7:0] TT    = 8'hE8,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             e,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [7:0]       cov,
  output logic             first_err_vld,
  output logic [2:0]       first_err_vec,
  output logic             first_err_got,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_FAIL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [7:0]       cov_q, cov_d;
  logic             fvld_q, fvld_d;
  logic [2:0]       fvec_q, fvec_d;
  logic             fgot_q, fgot_d;
  logic             pass_q, pass_d;

  logic [2:0]       idx;
  logic             exp_bit;
  logic             err_bit;
  logic             halted;
  logic             accept;

  // Register all results; synchronous active-low reset returns every output to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      cov_q      <= '0;
      fvld_q     <= 1'b0;
      fvec_q     <= '0;
      fgot_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      cov_q      <= cov_d;
      fvld_q     <= fvld_d;
      fvec_q     <= fvec_d;
      fgot_q     <= fgot_d;
      pass_q     <= pass_d;
    end
  end

  // Sample check, counters, first-failure capture and next-state decode.
  always_comb begin
    idx     = {a, b, c};
    exp_bit = TT[idx];
    // Case inequality so an X/Z on e counts as a mismatch in simulation.
    err_bit = (e !== exp_bit);
`ifdef BOOL_CHK_HALT_EN
    halted  = (state_q == S_FAIL);
`else
    halted  = 1'b0;
`endif
    accept  = in_valid & ~halted;

    state_d    = state_q;
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    cov_d      = cov_q;
    fvld_d     = fvld_q;
    fvec_d     = fvec_q;
    fgot_d     = fgot_q;

    if (accept) begin
      cov_d = cov_q | (8'b1 << idx);
      if (smp_cnt_q != CNT_MAX) smp_cnt_d = smp_cnt_q + CNT_ONE;
      if (err_bit) begin
        mismatch_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
        if (!fvld_q) begin
          fvld_d = 1'b1;
          fvec_d = idx;
          fgot_d = e;
        end
      end
      case (state_q)
        S_IDLE, S_RUN: state_d = (cov_d == 8'hFF) ? S_DONE : S_RUN;
        default:       state_d = state_q;
      endcase
`ifdef BOOL_CHK_HALT_EN
      if (err_bit) state_d = S_FAIL;
`endif
    end

    // clr wins over a concurrent sample, exactly like reset.
    if (clr) begin
      state_d    = S_IDLE;
      mismatch_d = 1'b0;
      err_cnt_d  = '0;
      smp_cnt_d  = '0;
      cov_d      = '0;
      fvld_d     = 1'b0;
      fvec_d     = '0;
      fgot_d     = 1'b0;
    end

    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  assign state         = state_q;
  assign mismatch      = mismatch_q;
  assign err_cnt       = err_cnt_q;
  assign smp_cnt       = smp_cnt_q;
  assign cov           = cov_q;
  assign first_err_vld = fvld_q;
  assign first_err_vec = fvec_q;
  assign first_err_got = fgot_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_bool3_resp_checker.sv
// Self-checking bench for bool3_resp_checker: two instances (CNT_W=8 and
// CNT_W=4) share one stimulus stream and one behavioural model.

module tb_bool3_resp_checker;

`ifdef BOOL_CHK_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, e = 1'b0, clr = 1'b0;

  logic [1:0] s8, s4;
  logic       mis8, mis4, fv8, fv4, fg8, fg4, pass8, pass4;
  logic [7:0] err8, smp8, cov8, cov4;
  logic [3:0] err4, smp4;
  logic [2:0] fvec8, fvec4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  logic [7:0] tt_v = 8'hE8;

  always #5 clk = ~clk;

  bool3_resp_checker #(.TT(8'hE8), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c), .e(e), .clr(clr),
    .state(s8), .mismatch(mis8), .err_cnt(err8), .smp_cnt(smp8), .cov(cov8),
    .first_err_vld(fv8), .first_err_vec(fvec8), .first_err_got(fg8), .pass(pass8));

  bool3_resp_checker #(.TT(8'hE8), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c), .e(e), .clr(clr),
    .state(s4), .mismatch(mis4), .err_cnt(err4), .smp_cnt(smp4), .cov(cov4),
    .first_err_vld(fv4), .first_err_vec(fvec4), .first_err_got(fg4), .pass(pass4));

  // Behavioural model: unbounded tallies, saturation applied only when compared.
  int       m_smp, m_err;
  bit [7:0] m_cov;
  bit       m_fvld, m_fgot, m_mis, m_started, m_fail;
  bit [2:0] m_fvec;

  always @(posedge clk) begin
    bit [2:0] ix;
    bit wrong;
    m_mis = 1'b0;
    if (!rst_n || clr) begin
      m_smp = 0; m_err = 0; m_cov = '0; m_fvld = 0; m_fgot = 0;
      m_fvec = '0; m_started = 0; m_fail = 0;
    end else if (in_valid && !m_fail) begin
      ix = {a, b, c};
      wrong = (e != tt_v[ix]);
      m_smp++;
      m_cov[ix] = 1'b1;
      m_started = 1'b1;
      if (wrong) begin
        m_err++;
        m_mis = 1'b1;
        if (!m_fvld) begin
          m_fvld = 1'b1; m_fvec = ix; m_fgot = e;
        end
        if (HALT) m_fail = 1'b1;
      end
    end
  end

  function automatic int sat(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int exp_state();
    if (!m_started) return 0;
    if (m_fail) return 3;
    if (m_cov == 8'hFF) return 2;
    return 1;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int es;
    if (chk_on) begin
      es = exp_state();
      check("state8", s8, es);
      check("mis8", mis8, m_mis);
      check("err8", err8, sat(m_err, 255));
      check("smp8", smp8, sat(m_smp, 255));
      check("cov8", cov8, m_cov);
      check("fvld8", fv8, m_fvld);
      check("fvec8", fvec8, m_fvec);
      check("fgot8", fg8, m_fgot);
      check("pass8", pass8, (es == 2 && m_err == 0) ? 1 : 0);
      check("state4", s4, es);
      check("mis4", mis4, m_mis);
      check("err4", err4, sat(m_err, 15));
      check("smp4", smp4, sat(m_smp, 15));
      check("cov4", cov4, m_cov);
      check("fvld4", fv4, m_fvld);
      check("fvec4", fvec4, m_fvec);
      check("fgot4", fg4, m_fgot);
      check("pass4", pass4, (es == 2 && m_err == 0) ? 1 : 0);
    end
  end

  task automatic put(input bit v, input bit [2:0] ix, input bit ev, input bit cl, input bit rn);
    @(posedge clk);
    #1;
    in_valid = v; {a, b, c} = ix; e = ev; clr = cl; rst_n = rn;
  endtask

  task automatic idle();
    put(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sweep(input bit inv);
    for (int i = 0; i < 8; i++)
      put(1'b1, i[2:0], tt_v[i] ^ (inv && (i == 3 || i == 6)), 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_on = 1'b1;
    check("rst_state", s8, 0);
    check("rst_cov", cov8, 0);
    check("rst_pass", pass8, 0);
    check("rst_smp", smp8, 0);

    // Clean sweep
    put(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    put(1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
    check("t1_run_after_first", s8, 1);
    for (int i = 2; i < 8; i++) put(1'b1, i[2:0], tt_v[i], 1'b0, 1'b1);
    idle();
    check("t1_state", s8, 2);
    check("t1_pass", pass8, 1);
    check("t1_smp", smp8, 8);
    check("t1_err", err8, 0);
    check("t1_cov", cov8, 8'hFF);

    // Sweep with wrong e at 011 and 110
    put(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) put(1'b1, i[2:0], tt_v[i] ^ (i == 3), 1'b0, 1'b1);
    put(1'b1, 3'd4, tt_v[4], 1'b0, 1'b1);
    check("t2_mis_pulse_011", mis8, 1);
    put(1'b1, 3'd5, tt_v[5], 1'b0, 1'b1);
    check("t2_mis_clear", mis8, 0);
    put(1'b1, 3'd6, ~tt_v[6], 1'b0, 1'b1);
    put(1'b1, 3'd7, tt_v[7], 1'b0, 1'b1);
    check("t2_mis_pulse_110", mis8, HALT ? 0 : 1);
    idle();
    check("t2_fvec", fvec8, 3);
    check("t2_fgot", fg8, 0);
    check("t2_pass", pass8, 0);
`ifdef BOOL_CHK_HALT_EN
    check("t2_state", s8, 3);
    check("t2_smp", smp8, 4);
    check("t2_err", err8, 1);
`else
    check("t2_state", s8, 2);
    check("t2_smp", smp8, 8);
    check("t2_err", err8, 2);
`endif

    // Gapped samples 000,000,101
    put(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    put(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    put(1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
    put(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    put(1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
    put(1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
    put(1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
    idle();
    check("t3_smp", smp8, 3);
    check("t3_cov", cov8, 8'h21);
    check("t3_state", s8, 1);
    check("t3_pass", pass8, 0);

    // 20 wrong samples: saturation
    put(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) put(1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
    idle();
`ifdef BOOL_CHK_HALT_EN
    check("t4_err4", err4, 1);
    check("t4_smp4", smp4, 1);
`else
    check("t4_err4_sat", err4, 15);
    check("t4_smp4_sat", smp4, 15);
    check("t4_err8", err8, 20);
`endif

    // clr concurrent with a wrong sample
    put(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    put(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    put(1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    put(1'b1, 3'd5, 1'b0, 1'b1, 1'b1);
    put(1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
    check("t5_clr_state", s8, 0);
    check("t5_clr_mis", mis8, 0);
    check("t5_clr_smp", smp8, 0);
    idle();
    check("t5_smp", smp8, 1);
    check("t5_state", s8, 1);

    // Reset while DONE
    put(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    sweep(1'b0);
    idle();
    check("t6_pre_state", s8, 2);
    put(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    idle();
    check("t6_state", s8, 0);
    check("t6_pass", pass8, 0);
    check("t6_cov", cov8, 0);
    check("t6_smp", smp8, 0);
    check("t6_err", err8, 0);
    check("t6_fvld", fv8, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
